status_code_packer: RTL and testbench

STATUS_CODE_PACKER -- requirements
Module: status_code_packer

---
 rtl/status_code_pkg.sv | 12 +
 rtl/status_idle_timer.sv | 29 ++
 rtl/status_code_packer.sv | 122 ++++++++++++
 tb/tb_status_code_packer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/status_code_pkg.sv
// Shared types and constants for the status code packer.
package status_code_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/status_idle_timer.sv
// Idle-cycle counter for a held low byte; flags the last idle cycle before a padded flush.
module status_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // Count idle cycles; clear has priority so every entry into the hold state starts at zero.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/status_code_packer.sv
// Packs a stream of status bytes into 16-bit payload words, padding a lone or stale low byte.
//
// state | meaning
// IDLE  | nothing held, output register empty
// HALF  | low byte held, waiting for its high byte or the idle timeout
// FULL  | word presented on pl, waiting for pl_rdy
module status_code_packer
  import status_code_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        code_vld,
  input  logic [7:0]  code,
  input  logic        code_last,
  output logic        code_rdy,
  output logic [15:0] pl,
  output logic        pl_vld,
  output logic        pl_last,
  output logic        pl_pad,
  input  logic        pl_rdy,
  output logic [15:0] word_cnt
);

  state_e      state_q, state_d;
  logic [7:0]  low_q, low_d;
  logic [15:0] pl_q, pl_d;
  logic        last_q, last_d;
  logic        pad_q, pad_d;
  logic [15:0] cnt_q, cnt_d;

  logic accept;
  logic xfer;
  logic expired;

  // In FULL a new byte can only enter if the current word leaves in the same cycle.
  assign code_rdy = (state_q == FULL) ? pl_rdy : 1'b1;
  assign accept   = code_vld & code_rdy;
  assign xfer     = (state_q == FULL) & pl_rdy;

  status_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (state_q != HALF),
    .enable ((state_q == HALF) & ~accept),
    .expired(expired)
  );

  // Next-state and output-register logic; a byte accepted outside HALF follows the empty-packer rules.
  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    pl_d    = pl_q;
    last_d  = last_q;
    pad_d   = pad_q;
    cnt_d   = cnt_q + {15'd0, xfer};

    case (state_q)
      IDLE: ;
      HALF: begin
        if (accept) begin
          state_d = FULL;
          pl_d    = {code, low_q};
          pad_d   = 1'b0;
          last_d  = code_last;
        end else if (expired) begin
          state_d = FULL;
          pl_d    = {PAD_BYTE, low_q};
          pad_d   = 1'b1;
          last_d  = 1'b0;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && (state_q != HALF)) begin
      if (code_last) begin
        state_d = FULL;
        pl_d    = {PAD_BYTE, code};
        pad_d   = 1'b1;
        last_d  = 1'b1;
      end else begin
        state_d = HALF;
        low_d   = code;
      end
    end
  end

  // State, held byte, output word and transfer counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      low_q   <= 8'h00;
      pl_q    <= 16'h0000;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      pl_q    <= pl_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pl       = pl_q;
  assign pl_vld   = (state_q == FULL);
  assign pl_last  = last_q;
  assign pl_pad   = pad_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_status_code_packer.sv
// Scoreboard bench for status_code_packer: directed scenarios followed by random traffic.
module tb_status_code_packer;

  localparam int TIMEOUT = 16;

  logic        clock;
  logic        rst_n;
  logic        code_vld;
  logic [7:0]  code;
  logic        code_last;
  logic        code_rdy;
  logic [15:0] pl;
  logic        pl_vld;
  logic        pl_last;
  logic        pl_pad;
  logic        pl_rdy;
  logic [15:0] word_cnt;

  typedef struct packed {
    logic [15:0] w;
    logic        last;
    logic        pad;
  } word_t;

  word_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  // Reference model state: at most one byte waiting for a partner.
  logic        holding = 1'b0;
  logic [7:0]  held = 8'h00;
  int          idle = 0;

  status_code_packer #(.TIMEOUT(TIMEOUT)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .code_vld (code_vld),
    .code     (code),
    .code_last(code_last),
    .code_rdy (code_rdy),
    .pl       (pl),
    .pl_vld   (pl_vld),
    .pl_last  (pl_last),
    .pl_pad   (pl_pad),
    .pl_rdy   (pl_rdy),
    .word_cnt (word_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected word whenever the DUT hands one over.
  always @(negedge clock) begin
    word_t e;
    #3;
    if (!rst_n) begin
      chk("rst_pl_vld", pl_vld, 0);
      chk("rst_pl", pl, 0);
      chk("rst_pl_last", pl_last, 0);
      chk("rst_pl_pad", pl_pad, 0);
      chk("rst_word_cnt", word_cnt, 0);
      exp_cnt = 16'd0;
    end else begin
      chk("pl_vld", pl_vld, (exp_q.size() != 0));
      chk("code_rdy", code_rdy, (exp_q.size() == 0) || pl_rdy);
      chk("word_cnt", word_cnt, exp_cnt);
      if (pl_vld && pl_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pl", pl, e.w);
          chk("pl_last", pl_last, e.last);
          chk("pl_pad", pl_pad, e.pad);
        end
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  // Reference model: pairs accepted bytes and flushes a stale byte after TIMEOUT idle edges.
  always @(negedge clock) begin
    #4;
    if (!rst_n) begin
      exp_q.delete();
      holding = 1'b0;
      idle = 0;
    end else if (code_vld && code_rdy) begin
      if (holding) begin
        exp_q.push_back('{w: {code, held}, last: code_last, pad: 1'b0});
        holding = 1'b0;
      end else if (code_last) begin
        exp_q.push_back('{w: {8'h00, code}, last: 1'b1, pad: 1'b1});
      end else begin
        holding = 1'b1;
        held = code;
        idle = 0;
      end
    end else if (holding) begin
      idle++;
      if (idle == TIMEOUT) begin
        exp_q.push_back('{w: {8'h00, held}, last: 1'b0, pad: 1'b1});
        holding = 1'b0;
      end
    end
  end

  // Call just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input logic [7:0] b, input logic last, output int tries);
    logic got;
    got = 1'b0;
    tries = 0;
    code_vld = 1'b1;
    code = b;
    code_last = last;
    for (int i = 0; i < 50; i++) begin
      #4;
      got = code_rdy;
      tries++;
      @(negedge clock);
      if (got) break;
    end
    if (!got) chk("send_timeout", 0, 1);
    code_vld = 1'b0;
    code_last = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    code_vld = 1'b0;
    code = 8'h00;
    code_last = 1'b0;
    pl_rdy = 1'b1;
    repeat (3) @(negedge clock);
    chk("rdy_in_reset", code_rdy, 1);
    rst_n = 1'b1;
    @(negedge clock);
    chk("rdy_after_reset", code_rdy, 1);

    // Basic pair.
    send(8'h12, 1'b0, t);
    send(8'h34, 1'b1, t);
    chk("pair_word", pl, 16'h3412);
    chk("pair_last", pl_last, 1);
    chk("pair_pad", pl_pad, 0);
    @(negedge clock);
    chk("pair_cnt", word_cnt, 16'd1);

    // Lone last byte appears one cycle after acceptance.
    send(8'hA5, 1'b1, t);
    chk("single_vld", pl_vld, 1);
    chk("single_word", pl, 16'h00A5);
    chk("single_pad", pl_pad, 1);
    chk("single_last", pl_last, 1);
    @(negedge clock);

    // Stale byte flushed after exactly TIMEOUT cycles in HALF.
    send(8'h5A, 1'b0, t);
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("timeout_early", pl_vld, 0);
      @(negedge clock);
    end
    chk("timeout_vld", pl_vld, 1);
    chk("timeout_word", pl, 16'h005A);
    chk("timeout_pad", pl_pad, 1);
    chk("timeout_last", pl_last, 0);
    @(negedge clock);

    // Back-to-back bytes at full rate.
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), (i == 8), t);
      chk("stream_rdy", t, 1);
    end
    @(negedge clock);

    // Downstream stall holds the word and blocks input.
    pl_rdy = 1'b0;
    send(8'hC3, 1'b1, t);
    code_vld = 1'b1;
    code = 8'h99;
    for (int k = 0; k < 5; k++) begin
      chk("stall_rdy", code_rdy, 0);
      chk("stall_word", pl, 16'h00C3);
      chk("stall_vld", pl_vld, 1);
      @(negedge clock);
    end
    code_vld = 1'b0;
    pl_rdy = 1'b1;
    @(negedge clock);
    chk("stall_release", pl_vld, 0);

    // Reset while a byte is held discards it.
    send(8'h77, 1'b0, t);
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      chk("rst_discard", pl_vld, 0);
      @(negedge clock);
    end
    send(8'h11, 1'b0, t);
    send(8'h22, 1'b0, t);
    chk("after_rst_word", pl, 16'h2211);
    @(negedge clock);

    // Random traffic with occasional long gaps to provoke timeouts.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        code_vld = 1'b0;
        pl_rdy = 1'b1;
        repeat (TIMEOUT + 3) @(negedge clock);
      end
      code_vld  = ($urandom_range(0, 99) < 60);
      code      = 8'($urandom);
      code_last = ($urandom_range(0, 3) == 0);
      pl_rdy    = ($urandom_range(0, 99) < 70);
      @(negedge clock);
    end
    code_vld = 1'b0;
    pl_rdy = 1'b1;
    repeat (TIMEOUT + 4) @(negedge clock);
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
